// File: rtl/cpri_bram_pkg.sv
// cpri_bram_pkg
//   Shared definitions for the CPRI block-RAM read controller:
//   - state_e        : burst sequencer states
//   - RD_LAT_DEFAULT : read latency of the RAM (1 RAM stage + 2 output registers)
package cpri_bram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int RD_LAT_DEFAULT = 3;

endpackage : cpri_bram_pkg

// File: rtl/cpri_rd_fifo.sv
// cpri_rd_fifo
//   Synchronous return buffer carrying {last, data} words from the RAM read
//   pipeline to the stream output. The head word is presented combinationally
//   from storage, so it stays stable until it is popped.
//   Ports:
//     clk, rst_n           : clock, async active-low reset
//     push, push_data,
//     push_last            : write side
//     pop                  : remove head word
//     head_data, head_last : current head word
//     count, full, empty   : occupancy status
module cpri_rd_fifo #(
  parameter int DATA_WIDTH = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          push_last,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         head_data,
  output logic                          head_last,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW:0]   CNT_ONE   = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_FULL  = (PW + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_r;
  logic [PW-1:0]       rd_ptr_r;
  logic [PW:0]         count_r;
  logic                wr_en_s;
  logic                rd_en_s;

  assign full    = (count_r == CNT_FULL);
  assign empty   = (count_r == {(PW + 1){1'b0}});
  assign count   = count_r;
  assign wr_en_s = push & ~full;
  assign rd_en_s = pop & ~empty;
  assign {head_last, head_data} = mem_r[rd_ptr_r];

  // Payload storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= {push_last, push_data};
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW + 1){1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  cpri_rd_fifo_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .full  (full)
  );

endmodule : cpri_rd_fifo

// File: rtl/cpri_rd_fifo_chk.sv
// cpri_rd_fifo_chk
//   Simulation checker for the return buffer.
//   Ports: clk, rst_n (async active-low), push (write request), full (buffer full).
module cpri_rd_fifo_chk (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic full
);

  // A push into a full buffer means the issue credit rule has been broken.
  ap_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule : cpri_rd_fifo_chk

// File: rtl/cpri_bram_rd_ctrl.sv
// cpri_bram_rd_ctrl
//   Reads a burst of words from a block RAM with a fixed read latency and
//   streams them out through a valid/ready interface. Reads are issued only
//   while the words already in flight plus the words buffered fit in the
//   return FIFO, so backpressure never loses data.
//   Ports:
//     clk, rst_n                : clock (also the RAM read clock), async active-low reset
//     start, base_addr, length  : burst request (length 0..NUMWORDS)
//     rdaddress, rden, ram_q    : RAM read port
//     m_data, m_valid, m_last,
//     m_ready                   : output stream
//     busy, done, err_start     : status (done / err_start are one-cycle pulses)
module cpri_bram_rd_ctrl
  import cpri_bram_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int NUMWORDS   = 256,
  parameter int RD_LAT     = RD_LAT_DEFAULT,
  parameter int FIFO_DEPTH = 8,
  localparam int AW        = $clog2(NUMWORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW:0]           length,
  output logic [AW-1:0]         rdaddress,
  output logic                  rden,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err_start
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW  = FCW + 1;
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(NUMWORDS - 1);
  localparam logic [AW:0]   LEN_ONE   = (AW + 1)'(1);
  localparam logic [CW-1:0] CREDIT    = CW'(FIFO_DEPTH);

  logic [1:0]            rst_sync_r;
  logic                  rst_i_n;
  state_e                state_r;
  state_e                next_state_s;
  logic [AW-1:0]         addr_r;
  logic [AW:0]           rem_r;
  logic [RD_LAT-1:0]     vs_r;
  logic [RD_LAT-1:0]     ls_r;
  logic                  done_r;
  logic                  err_r;
  logic                  rden_s;
  logic                  accept_s;
  logic                  zero_start_s;
  logic                  err_s;
  logic                  last_pop_s;
  logic                  pop_s;
  logic [CW-1:0]         outstanding_s;
  logic [CW-1:0]         credit_sum_s;
  logic                  credit_ok_s;
  logic [FCW-1:0]        fifo_count_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [DATA_WIDTH-1:0] head_data_s;
  logic                  head_last_s;

  // Reset synchronizer: asserts immediately, releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_i_n = rst_sync_r[1];

  // Words in flight = set bits of the valid-tracking shift register.
  always_comb begin
    outstanding_s = {CW{1'b0}};
    for (int i = 0; i < RD_LAT; i++) begin
      outstanding_s = outstanding_s + CW'(vs_r[i]);
    end
  end

  assign credit_sum_s = outstanding_s + CW'(fifo_count_s);
  assign credit_ok_s  = (credit_sum_s < CREDIT) & ~fifo_full_s;
  assign pop_s        = ~fifo_empty_s & m_ready;

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    next_state_s = state_r;
    rden_s       = 1'b0;
    accept_s     = 1'b0;
    zero_start_s = 1'b0;
    err_s        = 1'b0;
    last_pop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (length != {(AW + 1){1'b0}}) begin
            accept_s     = 1'b1;
            next_state_s = ST_ISSUE;
          end else begin
            zero_start_s = 1'b1;
            next_state_s = ST_IDLE;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        err_s = start;
        if (credit_ok_s) begin
          rden_s = 1'b1;
          if (rem_r == LEN_ONE) begin
            next_state_s = ST_DRAIN;
          end else begin
            next_state_s = ST_ISSUE;
          end
        end else begin
          next_state_s = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        err_s = start;
        if (pop_s && head_last_s) begin
          last_pop_s   = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Burst address/count, in-flight tracking and status pulses.
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      addr_r <= {AW{1'b0}};
      rem_r  <= {(AW + 1){1'b0}};
      vs_r   <= {RD_LAT{1'b0}};
      ls_r   <= {RD_LAT{1'b0}};
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        addr_r <= base_addr;
        rem_r  <= length;
      end else if (rden_s) begin
        addr_r <= (addr_r == ADDR_LAST) ? {AW{1'b0}} : addr_r + ADDR_ONE;
        rem_r  <= rem_r - LEN_ONE;
      end else begin
        addr_r <= addr_r;
        rem_r  <= rem_r;
      end
      // The last tag travels alongside its read so the FIFO marks it.
      vs_r[0] <= rden_s;
      ls_r[0] <= rden_s & (rem_r == LEN_ONE);
      for (int i = 1; i < RD_LAT; i++) begin
        vs_r[i] <= vs_r[i-1];
        ls_r[i] <= ls_r[i-1];
      end
      done_r <= zero_start_s | last_pop_s;
      err_r  <= err_s;
    end
  end

  cpri_rd_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_i_n),
    .push      (vs_r[RD_LAT-1]),
    .push_data (ram_q),
    .push_last (ls_r[RD_LAT-1]),
    .pop       (pop_s),
    .head_data (head_data_s),
    .head_last (head_last_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign rdaddress = addr_r;
  assign rden      = rden_s;
  assign m_data    = head_data_s;
  assign m_valid   = ~fifo_empty_s;
  assign m_last    = ~fifo_empty_s & head_last_s;
  assign busy      = (state_r != ST_IDLE);
  assign done      = done_r;
  assign err_start = err_r;

endmodule : cpri_bram_rd_ctrl

// File: tb/tb_cpri_bram_rd_ctrl.sv
// tb_cpri_bram_rd_ctrl
//   Directed bench for cpri_bram_rd_ctrl. The RAM is an array behind a fixed
//   three-stage read pipeline; a negedge monitor records issued addresses,
//   accepted words, done/err pulses and stall behaviour. Latencies are
//   counted from the clock edge that accepts start.
module tb_cpri_bram_rd_ctrl;

  localparam int DW = 256;
  localparam int NW = 256;
  localparam int AW = 8;
  localparam int RL = 3;
  localparam int FD = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [AW-1:0] rdaddress;
  logic          rden;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;
  logic          busy;
  logic          done;
  logic          err_start;

  logic [DW-1:0] mem  [NW];
  logic [DW-1:0] pipe [RL];

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  int n_issue = 0;
  int n_acc = 0;
  int n_done = 0;
  int n_errp = 0;
  int n_valid = 0;
  int max_inflight = 0;
  bit stall_bad = 1'b0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_data;

  logic [AW-1:0] iss_q[$];
  logic [DW-1:0] got_d[$];
  bit            got_l[$];
  int            acc_cyc_q[$];
  int            done_cyc_q[$];

  cpri_bram_rd_ctrl #(
    .DATA_WIDTH (DW),
    .NUMWORDS   (NW),
    .RD_LAT     (RL),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .rdaddress (rdaddress),
    .rden      (rden),
    .ram_q     (ram_q),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .busy      (busy),
    .done      (done),
    .err_start (err_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read registered, then two output register stages.
  always @(posedge clk) begin
    pipe[0] <= rden ? mem[rdaddress] : '0;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_q = pipe[RL-1];

  // Monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rden) begin
      iss_q.push_back(rdaddress);
      n_issue <= n_issue + 1;
    end
    if (n_issue + int'(rden) - n_acc > max_inflight)
      max_inflight <= n_issue + int'(rden) - n_acc;
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      got_d.push_back(m_data);
      got_l.push_back(m_last);
      acc_cyc_q.push_back(cyc);
      n_acc <= n_acc + 1;
    end
    if (m_valid === 1'b1) n_valid <= n_valid + 1;
    if (done === 1'b1) begin
      done_cyc_q.push_back(cyc);
      n_done <= n_done + 1;
    end
    if (err_start === 1'b1) n_errp <= n_errp + 1;
    if (prev_stall && !(m_valid === 1'b1 && m_data === prev_data)) stall_bad <= 1'b1;
    prev_stall <= (m_valid === 1'b1) && (m_ready === 1'b0);
    prev_data  <= m_data;
  end

  function automatic logic [DW-1:0] word_of(input int a);
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = 32'hA5C3_0000 ^ (32'(k) << 12) ^ 32'(a);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] a, input logic [AW:0] l, output int s);
    base_addr = a;
    length    = l;
    start     = 1'b1;
    step();
    s     = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int db, input int budget, input bit toggle);
    for (int i = 0; i < budget && n_done <= db; i++) begin
      if (toggle) m_ready = ((cyc % 4) == 0);
      step();
    end
    m_ready = 1'b1;
    chk("done_within_budget", (n_done > db), 1'b1);
  endtask

  // Compares n accepted words from index gb against addresses a0.. (wrapping) and the last flag.
  task automatic chk_burst(input string tag, input int gb, input int ib, input logic [AW-1:0] a0, input int n);
    int bad;
    logic [AW-1:0] ea;
    bad = 0;
    chk({tag, "_nwords"}, got_d.size() - gb, n);
    chk({tag, "_nissued"}, iss_q.size() - ib, n);
    if (got_d.size() >= gb + n && iss_q.size() >= ib + n) begin
      for (int i = 0; i < n; i++) begin
        ea = a0 + AW'(i);
        if (iss_q[ib+i] !== ea) bad++;
        if (got_d[gb+i] !== word_of(int'(ea))) bad++;
        if (got_l[gb+i] !== (i == n - 1)) bad++;
      end
      chk({tag, "_content_errors"}, bad, 0);
    end
  endtask

  initial begin
    int s, s2, gb, ib, db, vb, eb;
    logic [AW-1:0] ea;
    for (int a = 0; a < NW; a++) mem[a] = word_of(a);
    rst_n = 1'b0; start = 1'b0; m_ready = 1'b1; base_addr = '0; length = '0;
    repeat (3) step();
    chk("rst_rden", rden, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rdaddress", rdaddress, 8'h00);
    rst_n = 1'b1;
    repeat (4) step();

    // Basic burst, full throughput.
    gb = got_d.size(); ib = iss_q.size(); db = n_done;
    pulse_start(8'h10, 9'd4, s);
    wait_done(db, 40, 1'b0);
    repeat (3) step();
    chk_burst("t1", gb, ib, 8'h10, 4);
    if (acc_cyc_q.size() >= gb + 4) begin
      chk("t1_first_valid_latency", acc_cyc_q[gb] - s, 4);
      chk("t1_throughput", acc_cyc_q[gb+3] - acc_cyc_q[gb], 3);
      if (done_cyc_q.size() > db) chk("t1_done_timing", done_cyc_q[db] - acc_cyc_q[gb+3], 1);
    end
    chk("t1_done_once", n_done - db, 1);
    chk("t1_busy_low", busy, 1'b0);

    // Address wrap.
    gb = got_d.size(); ib = iss_q.size(); db = n_done;
    pulse_start(8'hFE, 9'd4, s);
    wait_done(db, 40, 1'b0);
    repeat (2) step();
    chk_burst("t2_wrap", gb, ib, 8'hFE, 4);
    if (iss_q.size() >= ib + 4) begin
      ea = iss_q[ib+2];
      chk("t2_third_addr", ea, 8'h00);
    end

    // Long burst with m_ready at 25% duty.
    gb = got_d.size(); ib = iss_q.size(); db = n_done;
    m_ready = 1'b0;
    pulse_start(8'h40, 9'd64, s);
    wait_done(db, 600, 1'b1);
    repeat (2) step();
    chk_burst("t3_stall", gb, ib, 8'h40, 64);
    chk("t3_inflight_le_depth", (max_inflight <= FD), 1'b1);
    chk("t3_stable_when_stalled", stall_bad, 1'b0);
    chk("t3_done_once", n_done - db, 1);

    // Zero-length request.
    ib = iss_q.size(); db = n_done; vb = n_valid;
    pulse_start(8'h05, 9'd0, s);
    repeat (6) step();
    chk("t4_done_once", n_done - db, 1);
    if (done_cyc_q.size() > db) chk("t4_done_next_cycle", done_cyc_q[db] - s, 0);
    chk("t4_no_rden", iss_q.size() - ib, 0);
    chk("t4_no_valid", n_valid - vb, 0);

    // Start while busy is rejected.
    gb = got_d.size(); ib = iss_q.size(); db = n_done; eb = n_errp;
    pulse_start(8'h20, 9'd8, s);
    step(); step();
    pulse_start(8'h80, 9'd2, s2);
    wait_done(db, 60, 1'b0);
    repeat (10) step();
    chk("t5_err_pulse", n_errp - eb, 1);
    chk_burst("t5_first", gb, ib, 8'h20, 8);
    chk("t5_done_once", n_done - db, 1);

    // Reset mid-burst.
    gb = got_d.size();
    pulse_start(8'h00, 9'd32, s);
    for (int i = 0; i < 40 && got_d.size() - gb < 5; i++) step();
    chk("t6_reached_5_words", (got_d.size() - gb >= 5), 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rden", rden, 1'b0);
    chk("t6_rst_m_valid", m_valid, 1'b0);
    chk("t6_rst_m_last", m_last, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_done", done, 1'b0);
    chk("t6_rst_err_start", err_start, 1'b0);
    chk("t6_rst_rdaddress", rdaddress, 8'h00);
    step(); step();
    rst_n = 1'b1;
    vb = n_valid; ib = iss_q.size();
    repeat (10) step();
    chk("t6_no_valid_after_release", n_valid - vb, 0);
    chk("t6_no_rden_after_release", iss_q.size() - ib, 0);
    gb = got_d.size(); ib = iss_q.size(); db = n_done;
    pulse_start(8'h30, 9'd2, s);
    wait_done(db, 40, 1'b0);
    repeat (2) step();
    chk_burst("t6_restart", gb, ib, 8'h30, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_cpri_bram_rd_ctrl
